or1k_trace_monitor: RTL and testbench
=====================================

# or1k_trace_monitor

Consumes the per-core `mor1kx_trace_exec` retirement stream that a compute tile exports as `trace`, and decodes simulation control `l.nop K` instructions. It keeps a shadow copy of GPR r3 and buffers `putc` characters in a FIFO drained over a valid/ready port. It also emits `report` values and drives the per-core `termination` flag the system testbench polls. One instance per core, clocked with the tile.

## Interface
- `FIFO_DEPTH`, 16: `putc` character FIFO entries; power of two, ≥2.
- `CNT_WIDTH`, 32: instruction counter width.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high. One clock; all state updates on rising `clk`.
- `trace_valid` in 1: one retired instruction this cycle.
- `trace_pc` in 32: PC of retired instruction.
- `trace_insn` in 32: retired instruction word.
- `trace_wben` in 1: retired instruction writes a GPR.
- `trace_wbreg` in 5: destination GPR index.
- `trace_wbdata` in 32: written value.
- `char_data` out 8: FIFO head character.
- `char_valid` out 1: FIFO non-empty.
- `char_ready` in 1: consumer accepts head.
- `report_valid` out 1: one-cycle pulse, `report` executed.
- `report_data` out 32: r3 value for report; holds until next report.
- `termination` out 1: sticky, program exited and FIFO drained.
- `exit_code` out 32: r3 at exit.
- `overflow_cnt` out 8: dropped characters, saturating at 255.
- `insn_count` out CNT_WIDTH: retired instructions.

## Operation
- Simulation control NOP: `trace_valid & trace_insn[31:24]==8'h15`; K = `trace_insn[15:0]`.
- Decoded K values:
  - 0x0001 exit: capture `exit_code`, leave RUN.
  - 0x0002 report: update `report_data`, pulse `report_valid`.
  - 0x0004 putc: push r3[7:0] into the FIFO.
  - Any other K: ordinary instruction.
- r3 used by any NOP is the shadow value before the current entry.
- Shadow update: on `trace_valid & trace_wben & trace_wbreg==3`, shadow ← `trace_wbdata`. This applies after NOP evaluation, so same-entry writeback is not visible to that entry.
- State machine:
  - RUN: decode everything. An exit entry moves to DRAIN.
  - DRAIN: ignore all trace entries, with no counting, reports, pushes or shadow updates. The FIFO still pops. Move to DONE on any edge where the FIFO count is 0.
  - DONE: terminal until `rst`.
  - `termination` = (state==DONE).
- FIFO:
  - Pop on `char_valid & char_ready`.
  - Push accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the character is dropped and `overflow_cnt` increments, saturating at 255.
  - Simultaneous push and pop leaves the count unchanged; data order is preserved.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Count is log2(FIFO_DEPTH)+1 bits.
- `insn_count` increments by 1 per valid entry in RUN, including control NOPs, and wraps modulo 2^CNT_WIDTH.
- Reset values: state RUN, shadow r3 0, FIFO empty, `char_valid` 0, `char_data` 0, `report_valid` 0, `report_data` 0, `termination` 0, `exit_code` 0, `overflow_cnt` 0, `insn_count` 0.
- A reset asserted mid-operation discards FIFO contents and returns to RUN on the same edge.

## Timing
- Entry sampled at edge E:
  - `report_valid` high in cycle E+1 for exactly one cycle.
  - A pushed character is visible on `char_valid`/`char_data` from E+1. There is no fall-through within the entry cycle.
- Exit at edge E: state is DRAIN after E.
  - If the FIFO is empty at E+1, DONE after edge E+1 and `termination` is high from then.
  - Otherwise DONE follows the edge after the last pop.
- `char_data` is driven from the registered head entry; `char_valid` is a function of registered count only.
- Back-to-back valid entries are accepted every cycle; there is no backpressure on trace.

## Configuration
- `OR1K_TRACE_MONITOR_INSN_COUNT_EN` defined: counter implemented as above.
- Undefined: no counter register; `insn_count` tied to 0. All other behaviour is identical.

## Test plan
- Report: write r3=0xDEADBEEF, then `l.nop 0x2` → `report_valid` one pulse the next cycle, `report_data`=0xDEADBEEF.
- Putc string: set r3 to 'H', `l.nop 0x4`, then 'i', `l.nop 0x4`, `char_ready`=1 → `char_data` 0x48 then 0x69, `overflow_cnt`=0.
- Overflow: `char_ready`=0, 20 putc entries with FIFO_DEPTH=16 → `overflow_cnt`=4, the first 16 characters drain in order once ready.
- Exit with pending FIFO: 3 chars queued, r3=0x2A, `l.nop 0x1`, `char_ready` raised 5 cycles later → `termination` stays 0 until after the 3rd pop, then 1; `exit_code`=0x2A; later entries have no effect.
- Same-entry hazard and reset: `l.nop 0x2` entry carrying `wben` to r3=0x5 with prior r3=0x7 → report 0x7, then shadow=0x5. `rst` during DRAIN → `termination`=0, FIFO empty, `insn_count`=0 the next cycle.
- Counter: 100 valid entries with macro defined → `insn_count`=100; macro undefined → 0.

Source files
------------

// File: rtl/or1k_trace_monitor.sv
// Per-core retirement-trace monitor: decodes l.nop simulation control, buffers putc output, reports, exit.
// Optional instruction counter is built only when OR1K_TRACE_MONITOR_INSN_COUNT_EN is defined.
module or1k_trace_monitor #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trace_valid,
  input  logic [31:0]          trace_pc,
  input  logic [31:0]          trace_insn,
  input  logic                 trace_wben,
  input  logic [4:0]           trace_wbreg,
  input  logic [31:0]          trace_wbdata,
  output logic [7:0]           char_data,
  output logic                 char_valid,
  input  logic                 char_ready,
  output logic                 report_valid,
  output logic [31:0]          report_data,
  output logic                 termination,
  output logic [31:0]          exit_code,
  output logic [7:0]           overflow_cnt,
  output logic [CNT_WIDTH-1:0] insn_count
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] insn;
    logic        wben;
    logic [4:0]  wbreg;
    logic [31:0] wbdata;
  } trace_t;

  trace_t tr;
  assign tr = '{valid: trace_valid, insn: trace_insn, wben: trace_wben,
                wbreg: trace_wbreg, wbdata: trace_wbdata};

  // PC and the middle opcode byte play no part in decode.
  logic unused_bits;
  assign unused_bits = ^{trace_pc, tr.insn[23:16]};

  state_t state, state_nxt;
  logic   running;
  assign running = (state == S_RUN);

  logic [31:0] shadow_r3;

  // Decode: only live in RUN, so DRAIN/DONE ignore the trace completely.
  logic is_nop, dec_exit, dec_report, dec_putc, sh_wr;
  always_comb begin
    is_nop     = tr.valid && (tr.insn[31:24] == 8'h15);
    dec_exit   = running && is_nop && (tr.insn[15:0] == 16'h0001);
    dec_report = running && is_nop && (tr.insn[15:0] == 16'h0002);
    dec_putc   = running && is_nop && (tr.insn[15:0] == 16'h0004);
    sh_wr      = running && tr.valid && tr.wben && (tr.wbreg == 5'd3);
  end

  // Character FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, pop, push, drop;

  always_comb begin
    full = count[PW];
    pop  = (count != '0) && char_ready;
    // A pop on the same edge frees the slot the push needs.
    push = dec_putc && (!full || pop);
    drop = dec_putc && !push;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shadow_r3[7:0];
  end

  assign char_valid = (count != '0);
  assign char_data  = char_valid ? mem[rd_ptr] : 8'h00;

  // Control registers; shadow update lands after the NOP has read the old r3.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r3    <= '0;
      report_valid <= 1'b0;
      report_data  <= '0;
      exit_code    <= '0;
      overflow_cnt <= '0;
    end else begin
      report_valid <= dec_report;
      if (dec_report) report_data <= shadow_r3;
      if (dec_exit)   exit_code   <= shadow_r3;
      if (drop && (overflow_cnt != 8'hFF)) overflow_cnt <= overflow_cnt + 1'b1;
      if (sh_wr) shadow_r3 <= tr.wbdata;
    end
  end

`ifdef OR1K_TRACE_MONITOR_INSN_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst)                     cnt_q <= '0;
    else if (running && tr.valid) cnt_q <= cnt_q + 1'b1;
  end
  assign insn_count = cnt_q;
`else
  assign insn_count = '0;
`endif

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (dec_exit) state_nxt = S_DRAIN;
      S_DRAIN: if (count == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    termination = (state == S_DONE);
  end
endmodule

// File: tb/tb_or1k_trace_monitor.sv
// Directed bench for or1k_trace_monitor: queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_or1k_trace_monitor;
  localparam int DEPTH = 16;
  localparam int CW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trace_valid = 1'b0;
  logic [31:0]   trace_pc = '0;
  logic [31:0]   trace_insn = '0;
  logic          trace_wben = 1'b0;
  logic [4:0]    trace_wbreg = '0;
  logic [31:0]   trace_wbdata = '0;
  logic [7:0]    char_data;
  logic          char_valid;
  logic          char_ready = 1'b0;
  logic          report_valid;
  logic [31:0]   report_data;
  logic          termination;
  logic [31:0]   exit_code;
  logic [7:0]    overflow_cnt;
  logic [CW-1:0] insn_count;

  always #5 clk = ~clk;

  or1k_trace_monitor #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_insn(trace_insn),
    .trace_wben(trace_wben), .trace_wbreg(trace_wbreg), .trace_wbdata(trace_wbdata),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .report_valid(report_valid), .report_data(report_data),
    .termination(termination), .exit_code(exit_code),
    .overflow_cnt(overflow_cnt), .insn_count(insn_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program-level view (exited/done flags, a byte queue).
  bit            chk_en = 0;
  bit            m_exited, m_done, m_rv;
  logic [31:0]   m_sh, m_rep, m_exit;
  int            m_ovf;
  logic [CW-1:0] m_cnt;
  byte unsigned  m_q[$];
  bit            mp_pop, mp_nop, mp_rep;
  logic [15:0]   mp_k;

  always @(posedge clk) begin
    if (rst) begin
      m_exited = 0; m_done = 0; m_rv = 0;
      m_sh = 0; m_rep = 0; m_exit = 0; m_ovf = 0; m_cnt = 0;
      m_q.delete();
      chk_en = 1;
    end else begin
      mp_pop = (m_q.size() > 0) && char_ready;
      mp_rep = 0;
      if (m_exited && m_q.size() == 0) m_done = 1;
      if (!m_exited) begin
        if (trace_valid) m_cnt = m_cnt + 1'b1;
        mp_nop = trace_valid && trace_insn[31:24] == 8'h15;
        mp_k   = trace_insn[15:0];
        if (mp_nop && mp_k == 16'h1) begin m_exit = m_sh; m_exited = 1; end
        if (mp_nop && mp_k == 16'h2) begin m_rep = m_sh; mp_rep = 1; end
        if (mp_pop) void'(m_q.pop_front());
        if (mp_nop && mp_k == 16'h4) begin
          if (m_q.size() < DEPTH) m_q.push_back(m_sh[7:0]);
          else if (m_ovf < 255) m_ovf++;
        end
        if (trace_valid && trace_wben && trace_wbreg == 5'd3) m_sh = trace_wbdata;
      end else if (mp_pop) begin
        void'(m_q.pop_front());
      end
      m_rv = mp_rep;
    end
  end

  // Characters actually consumed, captured on the accepting edge.
  byte unsigned got[$];
  always @(posedge clk) begin
    if (!rst && char_valid && char_ready) got.push_back(char_data);
  end

  logic [CW-1:0] exp_cnt;
  always @(negedge clk) begin
    if (chk_en) begin
`ifdef OR1K_TRACE_MONITOR_INSN_COUNT_EN
      exp_cnt = m_cnt;
`else
      exp_cnt = '0;
`endif
      chk("char_valid", char_valid, m_q.size() > 0);
      if (m_q.size() > 0) chk("char_data", char_data, m_q[0]);
      chk("report_valid", report_valid, m_rv);
      chk("report_data", report_data, m_rep);
      chk("termination", termination, m_done);
      chk("exit_code", exit_code, m_exit);
      chk("overflow_cnt", overflow_cnt, m_ovf);
      chk("insn_count", insn_count, exp_cnt);
    end
  end

  task automatic cyc(input logic v, input logic [31:0] insn, input logic we,
                     input logic [4:0] r, input logic [31:0] d);
    @(negedge clk);
    trace_valid = v; trace_insn = insn; trace_wben = we; trace_wbreg = r; trace_wbdata = d;
    trace_pc = trace_pc + 32'd4;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask
  task automatic wr_r3(input logic [31:0] v);
    cyc(1'b1, 32'hE0630000, 1'b1, 5'd3, v);
  endtask
  task automatic nop(input logic [15:0] k);
    cyc(1'b1, {8'h15, 8'h00, k}, 1'b0, 5'd0, 32'h0);
  endtask
  task automatic do_reset();
    @(negedge clk); rst = 1'b1; trace_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  int t_done;
  logic [CW-1:0] cnt_exp;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst char_valid", char_valid, 1'b0);
    chk("rst char_data", char_data, 8'h00);
    chk("rst report_valid", report_valid, 1'b0);
    chk("rst termination", termination, 1'b0);
    chk("rst exit_code", exit_code, 32'h0);
    chk("rst overflow", overflow_cnt, 8'h0);
    chk("rst insn_count", insn_count, '0);

    // Report
    wr_r3(32'hDEADBEEF); nop(16'h2); idle(1);
    chk("report pulse", report_valid, 1'b1);
    chk("report value", report_data, 32'hDEADBEEF);
    idle(1);
    chk("report pulse end", report_valid, 1'b0);

    // Putc string
    got.delete(); char_ready = 1'b1;
    wr_r3(32'h48); nop(16'h4); wr_r3(32'h69); nop(16'h4); idle(3);
    chk("putc count", got.size(), 2);
    if (got.size() == 2) begin
      chk("putc c0", got[0], 8'h48);
      chk("putc c1", got[1], 8'h69);
    end
    chk("putc overflow", overflow_cnt, 8'h0);

    // Overflow, saturation, then push while full with a pop
    char_ready = 1'b0; got.delete();
    for (int i = 0; i < 20; i++) begin wr_r3(32'h41 + i); nop(16'h4); end
    idle(1);
    chk("overflow 4", overflow_cnt, 8'd4);
    repeat (260) nop(16'h4);
    idle(1);
    chk("overflow sat", overflow_cnt, 8'd255);
    char_ready = 1'b1; nop(16'h4); idle(25);
    chk("drain count", got.size(), 17);
    if (got.size() == 17) begin
      for (int i = 0; i < 16; i++) chk("drain order", got[i], 8'h41 + i);
      chk("full push+pop", got[16], 8'h54);
    end
    chk("overflow held", overflow_cnt, 8'd255);

    // Exit with pending FIFO
    do_reset(); char_ready = 1'b0; got.delete();
    wr_r3(32'h61); nop(16'h4); wr_r3(32'h62); nop(16'h4); wr_r3(32'h63); nop(16'h4);
    wr_r3(32'h2A); nop(16'h1);
    nop(16'h2); wr_r3(32'h99); nop(16'h4); nop(16'h1);
    idle(1); char_ready = 1'b1;
    t_done = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (termination) begin t_done = i; break; end
    end
    chk("term latency", t_done, 4);
    chk("exit code", exit_code, 32'h2A);
    chk("exit chars", got.size(), 3);
    if (got.size() == 3) chk("exit char c", got[2], 8'h63);
    chk("drain ignores report", report_data, 32'h0);
    nop(16'h2); nop(16'h4); idle(2);
    chk("done sticky", termination, 1'b1);
    chk("done no push", char_valid, 1'b0);

    // Same-entry hazard, then reset during DRAIN
    do_reset();
    wr_r3(32'h7); cyc(1'b1, 32'h15000002, 1'b1, 5'd3, 32'h5); idle(1);
    chk("hazard report", report_data, 32'h7);
    nop(16'h2); idle(1);
    chk("hazard shadow", report_data, 32'h5);
    char_ready = 1'b0; nop(16'h4); nop(16'h4); nop(16'h1); idle(2);
    chk("drain pending", termination, 1'b0);
    do_reset();
    chk("rst drain term", termination, 1'b0);
    chk("rst drain fifo", char_valid, 1'b0);
    chk("rst drain cnt", insn_count, '0);

    // Counter, then exit on empty FIFO
    do_reset(); char_ready = 1'b1;
    for (int i = 0; i < 100; i++)
      cyc(1'b1, (i % 4 == 0) ? 32'h15000010 : 32'hE0632000 + i, (i % 5 == 0), 5'd3, i);
    idle(1);
`ifdef OR1K_TRACE_MONITOR_INSN_COUNT_EN
    cnt_exp = 100;
`else
    cnt_exp = 0;
`endif
    chk("insn_count 100", insn_count, cnt_exp);
    nop(16'h1); idle(1);
    chk("empty exit E+1", termination, 1'b0);
    idle(1);
    chk("empty exit E+2", termination, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
